// File: rtl/ex_mem_pipe_stage.sv
// rtl/ex_mem_pipe_stage.sv - elastic valid/ready pipeline stage with optional skid entry
module ex_mem_pipe_stage #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 166,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    // Head entry; it is what the downstream stage sees.
    logic              mainValid;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainData;

    // Second entry, only ever filled when SKID is enabled.
    logic              skidValid;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;

    logic [1:0]        countReg;

    logic              mainValidNext;
    logic [CTRL_W-1:0] mainCtrlNext;
    logic [DATA_W-1:0] mainDataNext;
    logic              skidValidNext;
    logic [CTRL_W-1:0] skidCtrlNext;
    logic [DATA_W-1:0] skidDataNext;
    logic [1:0]        countNext;

    logic              accept;
    logic              pop;

    // With the skid entry, ready depends only on a register, which cuts the
    // out_ready_i -> in_ready_o timing path between neighbouring stages.
    assign in_ready_o  = (SKID != 0) ? ~skidValid : (~mainValid | out_ready_i);
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = mainValid & out_ready_i;

    assign out_valid_o = mainValid;
    assign out_ctrl_o  = mainCtrl;
    assign out_data_o  = mainData;
    assign count_o     = countReg;

    // Next-state: flush wins, then skid drain, then accept/pop routing.
    always_comb begin
        mainValidNext = mainValid;
        mainCtrlNext  = mainCtrl;
        mainDataNext  = mainData;
        skidValidNext = skidValid;
        skidCtrlNext  = skidCtrl;
        skidDataNext  = skidData;

        if (flush_i) begin
            // Control is zeroed with the valid bit so a bubble never writes state;
            // data is left alone since nothing qualifies it.
            mainValidNext = 1'b0;
            mainCtrlNext  = '0;
            skidValidNext = 1'b0;
            skidCtrlNext  = '0;
        end else if (SKID != 0) begin
            if (skidValid) begin
                // in_ready_o is low here, so only a drain into main can happen.
                if (pop) begin
                    mainValidNext = 1'b1;
                    mainCtrlNext  = skidCtrl;
                    mainDataNext  = skidData;
                    skidValidNext = 1'b0;
                    skidCtrlNext  = '0;
                end
            end else if (accept && (!mainValid || pop)) begin
                mainValidNext = 1'b1;
                mainCtrlNext  = in_ctrl_i;
                mainDataNext  = in_data_i;
            end else if (accept) begin
                skidValidNext = 1'b1;
                skidCtrlNext  = in_ctrl_i;
                skidDataNext  = in_data_i;
            end else if (pop) begin
                mainValidNext = 1'b0;
                mainCtrlNext  = '0;
            end
        end else begin
            if (accept) begin
                mainValidNext = 1'b1;
                mainCtrlNext  = in_ctrl_i;
                mainDataNext  = in_data_i;
            end else if (pop) begin
                mainValidNext = 1'b0;
                mainCtrlNext  = '0;
            end
        end

        countNext = {1'b0, mainValidNext} + {1'b0, skidValidNext};
    end

    // State register; reset clears everything including the data bundles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            mainData  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            skidData  <= '0;
            countReg  <= 2'd0;
        end else begin
            mainValid <= mainValidNext;
            mainCtrl  <= mainCtrlNext;
            mainData  <= mainDataNext;
            skidValid <= skidValidNext;
            skidCtrl  <= skidCtrlNext;
            skidData  <= skidDataNext;
            countReg  <= countNext;
        end
    end

endmodule
